// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - state, coin and change encodings for the vending controller
package vending_pkg;

    localparam logic [1:0] S0        = 2'd0;
    localparam logic [1:0] S5        = 2'd1;
    localparam logic [1:0] S10       = 2'd2;
    localparam logic [1:0] S_ILLEGAL = 2'd3;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;
    localparam logic [1:0] COIN_BAD  = 2'd3;

    localparam logic [1:0] CHG_NONE  = 2'd0;
    localparam logic [1:0] CHG_5     = 2'd1;
    localparam logic [1:0] CHG_10    = 2'd2;

endpackage

// File: rtl/vending_machine.sv
// rtl/vending_machine.sv - 15-unit vending controller with change and idle refund
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic [1:0] c_state,
    output logic [1:0] n_state,
    output logic       out,
    output logic [1:0] change
);

    logic [1:0] r_c_state;
    logic       r_out;
    logic [1:0] r_change;

    logic [1:0] w_n_state;
    logic       w_out;
    logic [1:0] w_change;

    // Illegal state 3 falls to the default arm so it recovers even when in=3.
    always_comb begin
        w_n_state = S0;
        w_out     = 1'b0;
        w_change  = CHG_NONE;
        case (r_c_state)
            S0: begin
                case (in)
                    COIN_5:   w_n_state = S5;
                    COIN_10:  w_n_state = S10;
                    COIN_BAD: w_n_state = S0;
                    default:  w_n_state = S0;
                endcase
            end
            S5: begin
                case (in)
                    COIN_NONE: w_change = CHG_5;
                    COIN_5:    w_n_state = S10;
                    COIN_10:   w_out = 1'b1;
                    default:   w_n_state = S5;
                endcase
            end
            S10: begin
                case (in)
                    COIN_NONE: w_change = CHG_10;
                    COIN_5:    w_out = 1'b1;
                    COIN_10: begin
                        w_out    = 1'b1;
                        w_change = CHG_5;
                    end
                    default:   w_n_state = S10;
                endcase
            end
            default: w_n_state = S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_state <= S0;
            r_out     <= 1'b0;
            r_change  <= CHG_NONE;
        end else begin
            r_c_state <= w_n_state;
            r_out     <= w_out;
            r_change  <= w_change;
        end
    end

    assign c_state = r_c_state;
    assign n_state = w_n_state;
    assign out     = r_out;
    assign change  = r_change;

endmodule

// File: tb/tb_vending_machine.sv
// tb/tb_vending_machine.sv - scoreboard bench for vending_machine against a credit-based model
module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic [1:0] c_state;
    logic [1:0] n_state;
    logic       out;
    logic [1:0] change;

    vending_machine dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .c_state (c_state),
        .n_state (n_state),
        .out     (out),
        .change  (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       dsp;
        logic [1:0] chg;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;
    int   credit;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Customer-level model: credit in units, coin values summed, 15 buys the item.
    task automatic model_step(input int cr, input logic [1:0] coin,
                              output int new_cr, output int dsp, output int chg_units);
        int total;
        dsp = 0;
        chg_units = 0;
        new_cr = cr;
        if (coin == 2'd0) begin
            chg_units = cr;
            new_cr = 0;
        end else if (coin != 2'd3) begin
            total = cr + ((coin == 2'd1) ? 5 : 10);
            if (total >= 15) begin
                dsp = 1;
                chg_units = total - 15;
                new_cr = 0;
            end else begin
                new_cr = total;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("c_state[%0d]", e.idx), int'(c_state), int'(e.st));
                chk($sformatf("out[%0d]", e.idx), int'(out), int'(e.dsp));
                chk($sformatf("change[%0d]", e.idx), int'(change), int'(e.chg));
            end
        end
    end

    logic [2:0] vecs[$];

    initial begin
        logic [2:0] v;
        int nc, d, cu, tmo;
        exp_t e;
        n_vec = 0;
        n_bad = 0;
        credit = 0;
        rst = 1'b0;
        in = 2'd0;

        // {rst, in}: directed scenarios then random traffic with sporadic resets
        vecs = '{3'b0_00, 3'b1_00,
                 3'b1_01, 3'b1_01, 3'b1_01, 3'b1_00,
                 3'b1_10, 3'b1_10, 3'b1_10, 3'b1_00,
                 3'b1_01, 3'b1_00, 3'b1_10, 3'b1_00,
                 3'b1_10, 3'b0_00, 3'b1_00,
                 3'b1_01, 3'b1_11, 3'b1_11, 3'b1_01, 3'b1_00,
                 3'b1_10, 3'b1_11, 3'b1_00};
        for (int i = 0; i < 200; i++) begin
            v[1:0] = 2'($urandom_range(0, 3));
            v[2]   = ($urandom_range(0, 24) != 0);
            vecs.push_back(v);
        end

        #1;
        chk("reset_c_state", int'(c_state), 0);
        chk("reset_out", int'(out), 0);
        chk("reset_change", int'(change), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i][2];
            in  = vecs[i][1:0];
            if (!rst) credit = 0;
            #1;
            if (!rst) begin
                chk($sformatf("async_rst_c_state[%0d]", i), int'(c_state), 0);
                chk($sformatf("async_rst_out[%0d]", i), int'(out), 0);
                chk($sformatf("async_rst_change[%0d]", i), int'(change), 0);
            end
            model_step(credit, in, nc, d, cu);
            chk($sformatf("n_state[%0d]", i), int'(n_state), nc / 5);
            @(posedge clk);
            #1;
            if (rst) begin
                credit = nc;
                e.st = 2'(nc / 5);
                e.dsp = d[0];
                e.chg = 2'(cu / 5);
            end else begin
                e.st = 2'd0;
                e.dsp = 1'b0;
                e.chg = 2'd0;
            end
            e.idx = i;
            exp_q.push_back(e);
        end

        tmo = 0;
        while (exp_q.size() > 0 && tmo < 10) begin
            @(posedge clk);
            tmo++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        // Illegal state recovery
        @(negedge clk);
        rst = 1'b1;
        in  = 2'd3;
        force dut.r_c_state = 2'd3;
        #1;
        chk("illegal_n_state", int'(n_state), 0);
        release dut.r_c_state;
        @(posedge clk);
        #1;
        chk("illegal_recover_c_state", int'(c_state), 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
